capture_sequencer: RTL and testbench
====================================

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 0, SHALL set the first register-bus address decoded by the block.
REQ-002 Parameter SAMPLE_DEPTH, default 1024, SHALL set the sample-memory depth (power of two, >=4); ADDR_W = log2(SAMPLE_DEPTH).
REQ-003 Ports (name direction width meaning):
  clk  in  1  sole clock, all logic rising-edge.
  rst  in  1  asynchronous, active-high reset.
  trig_i  in  1  trigger condition from trigger block.
  addr_i / data_i  in  16 / 16  bus address / write data.
  rw_i / valid_i  in  1 / 1  bus 1=write, 0=read / request strobe.
  addr_o / data_o  out  16 / 16  bus address / data, forwarded.
  rw_o / valid_o  out  1 / 1  bus direction / strobe, forwarded.
  we_o  out  1  sample-memory write enable.
  write_addr_o  out  ADDR_W  sample-memory write address.
  state_o  out  3  current state encoding.

Function
REQ-004 States SHALL be IDLE=0, MOVE_TO_POSITION=1, IN_POSITION=2, CAPTURING=3, CAPTURED=4; other codes unreachable.
REQ-005 Registers SHALL be: BASE+0 state (RO); BASE+1 request_start (RW); BASE+2 request_stop (RW); BASE+3 trigger_loc (RW); BASE+4 read_pointer (RO); BASE+5 write_pointer (RO).
REQ-006 Bus SHALL have exactly one cycle latency: addr_o, rw_o, valid_o, data_o registered from inputs every cycle.
REQ-007 Read (valid_i=1, rw_i=0) hitting BASE..BASE+5 SHALL drive data_o with the zero-extended register value; all other cycles SHALL forward data_i.
REQ-008 Writes to RO addresses SHALL be ignored; the bus still forwards them.
REQ-009 trigger_loc writes SHALL be accepted only in IDLE or CAPTURED; values >= SAMPLE_DEPTH saturate to SAMPLE_DEPTH-1.
REQ-010 A 0->1 change of request_start in IDLE or CAPTURED SHALL clear both pointers and enter MOVE_TO_POSITION, or IN_POSITION directly if trigger_loc=0.
REQ-011 A 0->1 change of request_stop SHALL, from any state, enter IDLE and clear both pointers next cycle; it has priority over request_start and trig_i in the same cycle.
REQ-012 In MOVE_TO_POSITION, IN_POSITION and CAPTURING, we_o=1 each cycle, write_addr_o=write_pointer, write_pointer increments modulo SAMPLE_DEPTH; in IDLE and CAPTURED we_o=0.
REQ-013 MOVE_TO_POSITION SHALL last exactly trigger_loc cycles (addresses 0..trigger_loc-1), read_pointer held at 0; trig_i ignored.
REQ-014 IN_POSITION, trig_i=0: read_pointer increments with write_pointer (lag = trigger_loc).
REQ-015 IN_POSITION, trig_i=1: that cycle's write is the trigger sample, read_pointer frozen, next state CAPTURING.
REQ-016 CAPTURING SHALL write until SAMPLE_DEPTH-trigger_loc samples (trigger sample included) are written, then CAPTURED with we_o=0 the following cycle; trig_i ignored.
REQ-017 In CAPTURED, read_pointer SHALL address the oldest sample; trigger sample at (read_pointer+trigger_loc) mod SAMPLE_DEPTH.
REQ-018 state_o SHALL equal the state register.

Reset
REQ-019 rst SHALL asynchronously force IDLE, pointers 0, trigger_loc 0, request_start/stop 0, we_o 0, write_addr_o 0, valid_o 0, rw_o 0, addr_o 0, data_o 0.
REQ-020 rst mid-capture SHALL abort without further writes; a new capture needs a fresh request_start 0->1.

Verification (SAMPLE_DEPTH=8, BASE_ADDR=0)
REQ-021 After rst, read addr 0, 4, 5 -> 0, 0, 0 returned with valid_o one cycle after valid_i.
REQ-022 trigger_loc=3, start, trig_i at write_pointer=5 -> writes 0,1,2,3,4,5,6,7,0,1 then we_o=0; state=4; read_pointer=2; write_pointer=2.
REQ-023 trigger_loc=0, start, trig_i at write_pointer=3 -> IN_POSITION immediately; 8 writes 3..2; read_pointer=3.
REQ-024 request_stop 0->1 during CAPTURING -> IDLE next cycle, we_o=0, pointers read 0.
REQ-025 Write 20 to addr 3 in IDLE -> reads 7; write 2 during CAPTURING -> still reads 7.
REQ-026 Read addr 0x0040 with data_i=0xBEEF -> data_o=0xBEEF one cycle later; trig_i in MOVE_TO_POSITION -> no state change.

Source files
------------

// File: rtl/capture_sequencer.sv
// Capture sequencer: register-mapped control of pre/post-trigger sample capture into a circular memory.
// Bus path is a fixed one-cycle register stage with no backpressure; memory writes are combinational from state.
module capture_sequencer #(
    parameter  int unsigned BASE_ADDR    = 0,
    parameter  int unsigned SAMPLE_DEPTH = 1024,
    localparam int unsigned ADDR_W       = $clog2(SAMPLE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig_i,
    input  logic [15:0]       addr_i,
    input  logic [15:0]       data_i,
    input  logic              rw_i,
    input  logic              valid_i,
    output logic [15:0]       addr_o,
    output logic [15:0]       data_o,
    output logic              rw_o,
    output logic              valid_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] write_addr_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        MOVE_TO_POSITION = 3'd1,
        IN_POSITION      = 3'd2,
        CAPTURING        = 3'd3,
        CAPTURED         = 3'd4
    } state_t;

    localparam logic [15:0] BASE16 = 16'(BASE_ADDR);

    state_t              state_q, state_d;
    logic                req_start_q, req_start_d;
    logic                req_stop_q, req_stop_d;
    logic [ADDR_W-1:0]   trig_loc_q, trig_loc_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [15:0]         addr_q, data_q, data_d;
    logic                rw_q, valid_q;

    logic [16:0]         off_full;
    logic                hit;
    logic                wr_start, wr_stop, wr_tl;
    logic                start_rise, stop_rise;
    logic [ADDR_W-1:0]   tl_sat;
    logic                ctrl_idle;

    // Borrow in bit 16 means the address lies below the register window.
    assign off_full = {1'b0, addr_i} - {1'b0, BASE16};
    assign hit      = !off_full[16] && (off_full[15:0] < 16'd6);

    assign wr_start   = valid_i && rw_i && hit && (off_full[2:0] == 3'd1);
    assign wr_stop    = valid_i && rw_i && hit && (off_full[2:0] == 3'd2);
    assign wr_tl      = valid_i && rw_i && hit && (off_full[2:0] == 3'd3);
    assign start_rise = wr_start && data_i[0] && !req_start_q;
    assign stop_rise  = wr_stop && data_i[0] && !req_stop_q;
    assign ctrl_idle  = (state_q == IDLE) || (state_q == CAPTURED);

    assign tl_sat = ({16'd0, data_i} >= SAMPLE_DEPTH) ? ADDR_W'(SAMPLE_DEPTH - 1)
                                                      : data_i[ADDR_W-1:0];

    always_comb begin
        data_d = data_i;
        if (valid_i && !rw_i && hit) begin
            case (off_full[2:0])
                3'd0:    data_d = {13'd0, state_q};
                3'd1:    data_d = {15'd0, req_start_q};
                3'd2:    data_d = {15'd0, req_stop_q};
                3'd3:    data_d = 16'(trig_loc_q);
                3'd4:    data_d = 16'(rd_ptr_q);
                3'd5:    data_d = 16'(wr_ptr_q);
                default: data_d = data_i;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        req_start_d = req_start_q;
        req_stop_d  = req_stop_q;
        trig_loc_d  = trig_loc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        if (wr_start) req_start_d = data_i[0];
        if (wr_stop)  req_stop_d  = data_i[0];
        if (wr_tl && ctrl_idle) trig_loc_d = tl_sat;

        case (state_q)
            IDLE, CAPTURED: begin
                if (start_rise) begin
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    state_d  = (trig_loc_q == '0) ? IN_POSITION : MOVE_TO_POSITION;
                end
            end
            MOVE_TO_POSITION: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == trig_loc_q - 1'b1) state_d = IN_POSITION;
            end
            IN_POSITION: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (trig_i) begin
                    // With trigger_loc = depth-1 the trigger sample is the whole post-trigger window.
                    state_d = (wr_ptr_q == rd_ptr_q - 1'b1) ? CAPTURED : CAPTURING;
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            CAPTURING: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == rd_ptr_q - 1'b1) state_d = CAPTURED;
            end
            default: state_d = IDLE;
        endcase

        if (stop_rise) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_start_q <= 1'b0;
            req_stop_q  <= 1'b0;
            trig_loc_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_start_q <= req_start_d;
            req_stop_q  <= req_stop_d;
            trig_loc_q  <= trig_loc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            addr_q      <= addr_i;
            data_q      <= data_d;
            rw_q        <= rw_i;
            valid_q     <= valid_i;
        end
    end

    assign addr_o       = addr_q;
    assign data_o       = data_q;
    assign rw_o         = rw_q;
    assign valid_o      = valid_q;
    assign we_o         = (state_q == MOVE_TO_POSITION) || (state_q == IN_POSITION) ||
                          (state_q == CAPTURING);
    assign write_addr_o = wr_ptr_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer at depth 8: directed scenarios plus randomized captures against an arithmetic model.
module tb_capture_sequencer;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig_i;
    logic [15:0] addr_i, data_i;
    logic        rw_i, valid_i;
    logic [15:0] addr_o, data_o;
    logic        rw_o, valid_o;
    logic        we_o;
    logic [2:0]  write_addr_o;
    logic [2:0]  state_o;

    int vectors = 0;
    int errors  = 0;

    capture_sequencer #(.BASE_ADDR(0), .SAMPLE_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .trig_i(trig_i),
        .addr_i(addr_i), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
        .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o),
        .we_o(we_o), .write_addr_o(write_addr_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        valid_i = 1'b0;
        rw_i    = 1'b0;
        addr_i  = 16'h0;
        data_i  = 16'($urandom);
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [15:0] d);
        addr_i = a; data_i = d; rw_i = 1'b1; valid_i = 1'b1;
        tick();
        chk("wr_fwd_ctl", 32'({valid_o, rw_o, addr_o}), 32'({1'b1, 1'b1, a}));
        chk("wr_fwd_data", 32'(data_o), 32'(d));
        bus_idle();
    endtask

    task automatic reg_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
        addr_i = a; data_i = 16'($urandom); rw_i = 1'b0; valid_i = 1'b1;
        tick();
        chk("rd_ctl", 32'({valid_o, rw_o, addr_o}), 32'({1'b1, 1'b0, a}));
        chk(tag, 32'(data_o), 32'(exp));
        bus_idle();
    endtask

    // Model: writes form one address counter from 0; k idle IN_POSITION cycles precede the
    // trigger; total writes = k + D; both final pointers = k mod D; trigger sample at index tl+k.
    task automatic run_capture(input int tl_raw, input int k, input int inj_cycle,
                               input logic [15:0] inj_data);
        int   tl;
        int   q[$];
        int   c;
        int   rp_exp;
        logic done;
        tl     = (tl_raw >= D) ? D - 1 : tl_raw;
        rp_exp = k % D;
        reg_write(16'd3, 16'(tl_raw));
        reg_read(16'd3, 16'(tl), "trigger_loc_set");
        reg_write(16'd1, 16'd0);
        reg_write(16'd1, 16'd1);
        chk("start_state", 32'(state_o), (tl == 0) ? 32'd2 : 32'd1);
        done = 1'b0;
        c    = 0;
        while (!done && c < 200) begin
            if (c < tl)          trig_i = 1'($urandom);
            else if (c < tl + k) trig_i = 1'b0;
            else if (c == tl + k) trig_i = 1'b1;
            else                 trig_i = 1'($urandom);
            if (c == inj_cycle) begin
                addr_i = 16'd3; data_i = inj_data; rw_i = 1'b1; valid_i = 1'b1;
            end
            if (we_o) q.push_back(int'(write_addr_o));
            tick();
            bus_idle();
            c++;
            if (state_o == 3'd4) done = 1'b1;
        end
        trig_i = 1'b0;
        chk("capture_done", 32'(done), 32'd1);
        chk("we_after_capture", 32'(we_o), 32'd0);
        chk("write_count", 32'(q.size()), 32'(k + D));
        for (int i = 0; i < q.size(); i++) chk("write_addr", 32'(q[i]), 32'(i % D));
        if (q.size() > tl + k) chk("trigger_sample_addr", 32'(q[tl + k]), 32'((rp_exp + tl) % D));
        reg_read(16'd0, 16'd4, "state_reg_captured");
        reg_read(16'd4, 16'(rp_exp), "read_pointer");
        reg_read(16'd5, 16'(rp_exp), "write_pointer");
        reg_read(16'd3, 16'(tl), "trigger_loc_kept");
    endtask

    initial begin
        rst = 1'b1; trig_i = 1'b0;
        bus_idle();
        tick(); tick();
        chk("reset_ctl", 32'({state_o, we_o, write_addr_o, valid_o, rw_o}), 32'd0);
        chk("reset_addr_o", 32'(addr_o), 32'd0);
        chk("reset_data_o", 32'(data_o), 32'd0);
        rst = 1'b0;
        tick();

        reg_read(16'd0, 16'd0, "reset_state_reg");
        reg_read(16'd4, 16'd0, "reset_read_ptr");
        reg_read(16'd5, 16'd0, "reset_write_ptr");

        // Unmapped read forwards data_i; writes to read-only state are ignored.
        addr_i = 16'h0040; data_i = 16'hBEEF; rw_i = 1'b0; valid_i = 1'b1;
        tick();
        chk("unmapped_fwd", 32'(data_o), 32'h0000BEEF);
        bus_idle();
        reg_write(16'd0, 16'd3);
        reg_read(16'd0, 16'd0, "ro_state_ignored");

        run_capture(3, 2, -1, 16'd0);
        run_capture(0, 3, -1, 16'd0);

        reg_write(16'd3, 16'd20);
        reg_read(16'd3, 16'd7, "trigger_loc_saturated");
        run_capture(4, 1, 6, 16'd2);
        run_capture(7, 0, 2, 16'd1);

        // Stop while capturing, with a trigger pulse during MOVE_TO_POSITION first.
        reg_write(16'd2, 16'd0);
        reg_write(16'd3, 16'd2);
        reg_write(16'd1, 16'd0);
        reg_write(16'd1, 16'd1);
        trig_i = 1'b1; tick();
        chk("trig_ignored_in_move", 32'(state_o), 32'd1);
        trig_i = 1'b0; tick();
        chk("in_position", 32'(state_o), 32'd2);
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        chk("capturing", 32'(state_o), 32'd3);
        tick();
        addr_i = 16'd2; data_i = 16'd1; rw_i = 1'b1; valid_i = 1'b1;
        tick();
        bus_idle();
        chk("stop_state", 32'(state_o), 32'd0);
        chk("stop_we", 32'(we_o), 32'd0);
        reg_read(16'd4, 16'd0, "stop_read_ptr");
        reg_read(16'd5, 16'd0, "stop_write_ptr");
        reg_read(16'd2, 16'd1, "stop_reg_value");
        reg_write(16'd2, 16'd0);

        // Asynchronous reset in the middle of a capture.
        reg_write(16'd3, 16'd5);
        reg_write(16'd1, 16'd0);
        reg_write(16'd1, 16'd1);
        tick();
        chk("pre_reset_we", 32'(we_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_state", 32'({state_o, we_o, write_addr_o}), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("post_reset_no_write", 32'({state_o, we_o}), 32'd0);
        reg_read(16'd1, 16'd0, "post_reset_start_reg");
        reg_read(16'd3, 16'd0, "post_reset_trigger_loc");

        for (int n = 0; n < 8; n++) begin
            run_capture(int'($urandom_range(0, 15)), int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 5)), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
